// File: rtl/shifter_stage.sv
// shifter_stage: barrel-shifter pipeline stage between operand decode and ALU.
// Selects the shifter source (immediate, forwarded writeback or register file),
// applies LSL/LSR/ASR/ROR/RRX with carry-out, and buffers results in an output
// register backed by a single skid register so in_ready can be registered.
// The ROR amount is reduced modulo FULLW by bit slicing, so FULLW is expected
// to be a power of two.
module shifter_stage #(
  parameter int FULLW      = 32,
  parameter int REGAW      = 4,
  parameter int SHIFTCODEW = 2,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REGAW-1:0]      rm,
  input  logic [FULLW-1:0]      rm_data,
  input  logic [FULLW-1:0]      bypass_rm,
  input  logic                  should_bypass_rm,
  input  logic [SHIFTCODEW-1:0] shiftcode,
  input  logic [WIDTH-1:0]      shiftby,
  input  logic                  carry_in,
  input  logic                  fwd_valid,
  input  logic [REGAW-1:0]      fwd_reg,
  input  logic [FULLW-1:0]      fwd_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FULLW-1:0]      out_operand,
  output logic                  out_carry
);

  localparam int SAW = $clog2(FULLW);
  localparam logic [WIDTH-1:0] W_FULL = WIDTH'(FULLW);
  localparam logic [WIDTH-1:0] W_ZERO = {WIDTH{1'b0}};
  localparam logic [SHIFTCODEW-1:0] SH_LSL = SHIFTCODEW'(0);
  localparam logic [SHIFTCODEW-1:0] SH_LSR = SHIFTCODEW'(1);
  localparam logic [SHIFTCODEW-1:0] SH_ASR = SHIFTCODEW'(2);
  localparam logic [SHIFTCODEW-1:0] SH_ROR = SHIFTCODEW'(3);

  // Returns {carry_out, result}. Shifts are done on a FULLW+1 wide vector so the
  // last bit shifted out lands in the extra position and becomes the carry.
  function automatic logic [FULLW:0] shift_op(
    input logic [FULLW-1:0]      src,
    input logic [SHIFTCODEW-1:0] code,
    input logic [WIDTH-1:0]      n,
    input logic                  cin
  );
    logic [FULLW:0]     t;
    logic [FULLW:0]     res;
    logic [2*FULLW-1:0] dbl;
    logic [WIDTH-1:0]   amt;
    logic [WIDTH-1:0]   amt_c;
    res   = {(FULLW+1){1'b0}};
    t     = {(FULLW+1){1'b0}};
    dbl   = {(2*FULLW){1'b0}};
    // LSR#0 and ASR#0 encode a full-width shift
    amt   = (n == W_ZERO) ? W_FULL : n;
    amt_c = (amt > W_FULL) ? W_FULL : amt;
    case (code)
      SH_LSL: begin
        if (n == W_ZERO) begin
          res = {cin, src};
        end else if (n > W_FULL) begin
          res = {(FULLW+1){1'b0}};
        end else begin
          t   = {1'b0, src} << n;
          res = t;
        end
      end
      SH_LSR: begin
        if (amt > W_FULL) begin
          res = {(FULLW+1){1'b0}};
        end else begin
          t   = {src, 1'b0} >> amt;
          res = {t[0], t[FULLW:1]};
        end
      end
      SH_ASR: begin
        // Amounts beyond FULLW saturate: every bit and the carry become the sign
        t   = $signed({src, 1'b0}) >>> amt_c;
        res = {t[0], t[FULLW:1]};
      end
      SH_ROR: begin
        if (n == W_ZERO) begin
          res = {src[0], cin, src[FULLW-1:1]};
        end else begin
          dbl = {src, src} >> n[SAW-1:0];
          res = {dbl[FULLW-1], dbl[FULLW-1:0]};
        end
      end
      default: begin
        res = {cin, src};
      end
    endcase
    return res;
  endfunction

  logic             r_out_valid;
  logic [FULLW-1:0] r_out_operand;
  logic             r_out_carry;
  logic             r_skid_valid;
  logic [FULLW-1:0] r_skid_operand;
  logic             r_skid_carry;
  logic             r_in_ready;

  logic             w_accept;
  logic             w_out_free;
  logic [FULLW-1:0] w_src;
  logic [FULLW:0]   w_shift;
  logic             w_out_valid_nxt;
  logic [FULLW-1:0] w_out_operand_nxt;
  logic             w_out_carry_nxt;
  logic             w_skid_valid_nxt;
  logic [FULLW-1:0] w_skid_operand_nxt;
  logic             w_skid_carry_nxt;

  assign w_accept   = in_valid & r_in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  // Pick the shifter source: immediate, then same-cycle writeback, then regfile
  always_comb begin
    w_src = rm_data;
    if (should_bypass_rm) begin
      w_src = bypass_rm;
    end else if (fwd_valid && (fwd_reg == rm)) begin
      w_src = fwd_data;
    end else begin
      w_src = rm_data;
    end
    w_shift = shift_op(w_src, shiftcode, shiftby, carry_in);
  end

  // Next state of output and skid registers; flush overrides accept and consume
  always_comb begin
    w_out_valid_nxt    = r_out_valid;
    w_out_operand_nxt  = r_out_operand;
    w_out_carry_nxt    = r_out_carry;
    w_skid_valid_nxt   = r_skid_valid;
    w_skid_operand_nxt = r_skid_operand;
    w_skid_carry_nxt   = r_skid_carry;
    if (flush) begin
      w_out_valid_nxt  = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_out_free) begin
      // in_ready is low whenever the skid is full, so no accept competes here
      if (r_skid_valid) begin
        w_out_valid_nxt   = 1'b1;
        w_out_operand_nxt = r_skid_operand;
        w_out_carry_nxt   = r_skid_carry;
        w_skid_valid_nxt  = 1'b0;
      end else if (w_accept) begin
        w_out_valid_nxt   = 1'b1;
        w_out_operand_nxt = w_shift[FULLW-1:0];
        w_out_carry_nxt   = w_shift[FULLW];
      end else begin
        w_out_valid_nxt = 1'b0;
      end
    end else begin
      if (w_accept) begin
        w_skid_valid_nxt   = 1'b1;
        w_skid_operand_nxt = w_shift[FULLW-1:0];
        w_skid_carry_nxt   = w_shift[FULLW];
      end else begin
        w_skid_valid_nxt = r_skid_valid;
      end
    end
  end

  // Buffer registers; in_ready tracks whether the skid will be empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_out_operand  <= {FULLW{1'b0}};
      r_out_carry    <= 1'b0;
      r_skid_valid   <= 1'b0;
      r_skid_operand <= {FULLW{1'b0}};
      r_skid_carry   <= 1'b0;
      r_in_ready     <= 1'b0;
    end else begin
      r_out_valid    <= w_out_valid_nxt;
      r_out_operand  <= w_out_operand_nxt;
      r_out_carry    <= w_out_carry_nxt;
      r_skid_valid   <= w_skid_valid_nxt;
      r_skid_operand <= w_skid_operand_nxt;
      r_skid_carry   <= w_skid_carry_nxt;
      r_in_ready     <= ~w_skid_valid_nxt;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_operand = r_out_operand;
  assign out_carry   = r_out_carry;

endmodule

// File: tb/tb_shifter_stage.sv
// Testbench for shifter_stage: directed steps plus a short random run; every
// accepted operand pushes its expected {carry, operand} into a queue that is
// popped and compared when the stage hands a result downstream.
module tb_shifter_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  rm = 4'd0;
  logic [31:0] rm_data = 32'd0;
  logic [31:0] bypass_rm = 32'd0;
  logic        should_bypass_rm = 1'b0;
  logic [1:0]  shiftcode = 2'd0;
  logic [7:0]  shiftby = 8'd0;
  logic        carry_in = 1'b0;
  logic        fwd_valid = 1'b0;
  logic [3:0]  fwd_reg = 4'd0;
  logic [31:0] fwd_data = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_operand;
  logic        out_carry;

  int checks = 0;
  int errors = 0;
  logic [32:0] sb[$];

  shifter_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rm(rm), .rm_data(rm_data), .bypass_rm(bypass_rm),
    .should_bypass_rm(should_bypass_rm), .shiftcode(shiftcode),
    .shiftby(shiftby), .carry_in(carry_in), .fwd_valid(fwd_valid),
    .fwd_reg(fwd_reg), .fwd_data(fwd_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operand(out_operand), .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  // Reference shifter written straight from the ARM-style shift rules
  function automatic logic [32:0] model(input logic [31:0] src, input logic [1:0] code,
                                        input logic [7:0] n, input logic cin);
    int k;
    int m;
    logic [31:0] r;
    logic c;
    k = int'(n);
    r = 32'd0;
    c = 1'b0;
    case (code)
      2'd0: begin
        if (k == 0) begin r = src; c = cin; end
        else if (k < 32) begin r = src << k; c = src[32-k]; end
        else if (k == 32) begin r = 32'd0; c = src[0]; end
        else begin r = 32'd0; c = 1'b0; end
      end
      2'd1: begin
        if (k == 0) k = 32;
        if (k < 32) begin r = src >> k; c = src[k-1]; end
        else if (k == 32) begin r = 32'd0; c = src[31]; end
        else begin r = 32'd0; c = 1'b0; end
      end
      2'd2: begin
        if (k == 0) k = 32;
        if (k < 32) begin r = $signed(src) >>> k; c = src[k-1]; end
        else begin r = {32{src[31]}}; c = src[31]; end
      end
      default: begin
        if (k == 0) begin r = {cin, src[31:1]}; c = src[0]; end
        else begin
          m = k % 32;
          r = (m == 0) ? src : ((src >> m) | (src << (32 - m)));
          c = r[31];
        end
      end
    endcase
    return {c, r};
  endfunction

  function automatic logic [31:0] sel_src();
    if (should_bypass_rm) return bypass_rm;
    else if (fwd_valid && (fwd_reg == rm)) return fwd_data;
    else return rm_data;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs set: score the coming edge, then advance
  task automatic cycle(output bit acc);
    logic [32:0] e;
    bit con;
    acc = in_valid && in_ready && !flush;
    con = out_valid && out_ready && !flush;
    if (flush) sb.delete();
    if (con) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {31'd0, out_carry, out_operand}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_operand", {32'd0, out_operand}, {32'd0, e[31:0]});
        chk("sb_carry", {63'd0, out_carry}, {63'd0, e[32]});
      end
    end
    if (acc) sb.push_back(model(sel_src(), shiftcode, shiftby, carry_in));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [1:0] code, input logic [7:0] n,
                        input logic [31:0] src, input logic cin);
    shiftcode = code; shiftby = n; rm_data = src; carry_in = cin;
  endtask

  task automatic drain();
    bit a;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      cycle(a);
    end
    chk("drain_queue_empty", 64'(sb.size()), 64'd0);
    chk("drain_out_valid", {63'd0, out_valid}, 64'd0);
  endtask

  typedef struct { logic [1:0] code; logic [7:0] n; logic [31:0] src; logic cin; } op_t;

  initial begin
    bit acc;
    op_t ops[$];
    op_t o;
    int guard;
    // Reset state is applied without any clock edge
    reset = 1'b1;
    #2;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_operand", {32'd0, out_operand}, 64'd0);
    chk("rst_out_carry", {63'd0, out_carry}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready_held", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    // LSL#4 with one-cycle latency
    out_ready = 1'b1;
    set_op(2'd0, 8'd4, 32'h8000_000F, 1'b0);
    in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    chk("lsl4_latency", {63'd0, out_valid}, 64'd1);
    chk("lsl4_operand", {32'd0, out_operand}, 64'h0000_00F0);
    chk("lsl4_carry", {63'd0, out_carry}, 64'd0);
    cycle(acc);

    // RRX
    set_op(2'd3, 8'd0, 32'h0000_0003, 1'b1);
    in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    chk("rrx_operand", {32'd0, out_operand}, 64'h8000_0001);
    chk("rrx_carry", {63'd0, out_carry}, 64'd1);
    cycle(acc);

    // ASR#0 behaves as ASR#32
    set_op(2'd2, 8'd0, 32'h8000_0000, 1'b0);
    in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    chk("asr0_operand", {32'd0, out_operand}, 64'hFFFF_FFFF);
    chk("asr0_carry", {63'd0, out_carry}, 64'd1);
    cycle(acc);

    // Boundary amounts, back to back at full throughput
    ops.push_back('{2'd0, 8'd32, 32'h0000_0001, 1'b0});
    ops.push_back('{2'd0, 8'd33, 32'hFFFF_FFFF, 1'b1});
    ops.push_back('{2'd0, 8'd31, 32'h0000_0003, 1'b0});
    ops.push_back('{2'd1, 8'd0, 32'h8000_0000, 1'b0});
    ops.push_back('{2'd1, 8'd1, 32'h0000_0003, 1'b0});
    ops.push_back('{2'd1, 8'd40, 32'hFFFF_FFFF, 1'b1});
    ops.push_back('{2'd2, 8'd4, 32'h8000_0010, 1'b0});
    ops.push_back('{2'd2, 8'd33, 32'h7FFF_FFFF, 1'b1});
    ops.push_back('{2'd3, 8'd4, 32'h0000_000F, 1'b0});
    ops.push_back('{2'd3, 8'd36, 32'h0000_000F, 1'b0});
    ops.push_back('{2'd3, 8'd32, 32'h8000_0000, 1'b0});
    ops.push_back('{2'd0, 8'd255, 32'h1234_5678, 1'b1});
    out_ready = 1'b1;
    foreach (ops[i]) begin
      set_op(ops[i].code, ops[i].n, ops[i].src, ops[i].cin);
      in_valid = 1'b1;
      cycle(acc);
      chk("throughput_accept", {63'd0, acc}, 64'd1);
    end
    drain();

    // Backpressure: A held, B in skid, C refused
    out_ready = 1'b0;
    set_op(2'd0, 8'd1, 32'h0000_00A0, 1'b0);
    in_valid = 1'b1;
    cycle(acc);
    set_op(2'd0, 8'd2, 32'h0000_00B0, 1'b0);
    cycle(acc);
    chk("bp_b_accepted", {63'd0, acc}, 64'd1);
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    set_op(2'd0, 8'd3, 32'h0000_00C0, 1'b0);
    cycle(acc);
    chk("bp_c_refused", {63'd0, acc}, 64'd0);
    cycle(acc);
    chk("bp_hold_operand", {32'd0, out_operand}, 64'h0000_0140);
    chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 10) begin
      cycle(acc);
      guard++;
    end
    chk("bp_c_eventually_accepted", {63'd0, acc}, 64'd1);
    drain();

    // Forwarding and immediate selection
    out_ready = 1'b1;
    rm = 4'd5; fwd_valid = 1'b1; fwd_reg = 4'd5; fwd_data = 32'h0000_1234;
    set_op(2'd0, 8'd0, 32'h0000_DEAD, 1'b0);
    in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    chk("fwd_operand", {32'd0, out_operand}, 64'h0000_1234);
    should_bypass_rm = 1'b1; bypass_rm = 32'h0000_00FF;
    in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    chk("bypass_operand", {32'd0, out_operand}, 64'h0000_00FF);
    should_bypass_rm = 1'b0; fwd_valid = 1'b0;
    drain();

    // A writeback after acceptance must not disturb the buffered result
    out_ready = 1'b0;
    in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    fwd_valid = 1'b1; fwd_reg = 4'd5; fwd_data = 32'h0000_9999;
    cycle(acc);
    chk("late_fwd_ignored", {32'd0, out_operand}, 64'h0000_DEAD);
    fwd_valid = 1'b0;
    drain();

    // Flush with both buffers full and a new input present
    out_ready = 1'b0;
    set_op(2'd0, 8'd1, 32'h0000_0011, 1'b0);
    in_valid = 1'b1;
    cycle(acc);
    set_op(2'd0, 8'd1, 32'h0000_0022, 1'b0);
    cycle(acc);
    set_op(2'd0, 8'd1, 32'h0000_0033, 1'b0);
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle(acc);
    chk("flush_nothing_emerges", {63'd0, out_valid}, 64'd0);

    // Random traffic with random backpressure
    in_valid = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        o.code = 2'($urandom_range(0, 3));
        o.n = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 34));
        o.src = $urandom();
        o.cin = 1'($urandom_range(0, 1));
        set_op(o.code, o.n, o.src, o.cin);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cycle(acc);
    end
    drain();

    // Asynchronous reset between edges while a result is held
    out_ready = 1'b0;
    set_op(2'd0, 8'd4, 32'h0000_0005, 1'b0);
    in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("async_rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("async_rst_operand", {32'd0, out_operand}, 64'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle(acc);
    chk("post_reset_no_output", {63'd0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
